// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_pkg
//  Purpose  : Shared definitions for the console serial output port:
//             default bus address, status register bit positions and the
//             transmit state machine encoding.
//  Revision : 1.0  initial release
// ============================================================================
package io_pkg;

    // Data register address; the status register sits at the next address.
    localparam logic [15:0] CONSOLE_BASE = 16'h0004;

    // Status register bit positions.
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    // Transmit state machine encoding.
    localparam int          TX_STATE_W = 2;
    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_START    = 2'd1;
    localparam logic [1:0]  S_DATA     = 2'd2;
    localparam logic [1:0]  S_STOP     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/serial_out_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_out_port_if
//  Purpose  : CPU-side control signals of the console serial output port.
//             The shared 16-bit data bus is a resolved tri-state net and is
//             carried as a separate inout port on the device.
//  Signals  : addr  CPU address
//             DI    CPU write strobe
//             DO    CPU read strobe
//             tx    serial output, idle high
//             irq   high while all queued output has drained
//  Modports : master (CPU / system side), slave (device side)
//  Revision : 1.0  initial release
// ============================================================================
interface serial_out_port_if;
    logic [15:0] addr;
    logic        DI;
    logic        DO;
    logic        tx;
    logic        irq;

    modport master (output addr, output DI, output DO, input  tx, input  irq);
    modport slave  (input  addr, input  DI, input  DO, output tx, output irq);
endinterface
`default_nettype wire

// File: rtl/serial_out_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with first-word-fall-through read data.
//             When full, a pop on the same edge frees the slot first so a
//             simultaneous push is accepted.
//  Ports    : clk, rst      clock, asynchronous active-high reset
//             i_push/i_data write request and data
//             i_pop         read request (head is consumed)
//             o_data        current head entry
//             o_full/o_empty occupancy flags
//             o_drop        push rejected this cycle (full, no pop)
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_drop
);
    localparam int c_AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;
    assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end
endmodule
`default_nettype wire

// File: rtl/serial_out_port.sv
`default_nettype none
// ============================================================================
//  Module   : serial_out_port
//  Purpose  : Memory-mapped console output device. CPU writes to BASE queue
//             a byte; the queue drains as 8N1 serial on tx. CPU reads of
//             BASE+1 return {overflow, empty, full, busy}.
//  Ports    : clk    clock
//             reset  asynchronous active-high reset
//             bus    shared 16-bit data bus (driven only on status reads)
//             cpu    addr/DI/DO strobes in, tx/irq out (slave modport)
//  Params   : BASE   data register address (status at BASE+1)
//             DEPTH  FIFO entries (power of two, >=2)
//             CLKDIV clk cycles per serial bit (>=1)
//  Revision : 1.0  initial release
// ============================================================================
module serial_out_port
    import io_pkg::*;
#(
    parameter logic [15:0] BASE   = CONSOLE_BASE,
    parameter int          DEPTH  = 4,
    parameter int          CLKDIV = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    inout  wire       [15:0] bus,
    serial_out_port_if.slave cpu
);
    localparam logic [15:0] c_STATUS_ADDR = BASE + 16'd1;
    localparam int          c_CW          = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKDIV - 1);

    logic [TX_STATE_W-1:0] r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  r_ovf;
    logic                  r_irq;

    logic        w_wr_data;
    logic        w_st_access;
    logic        w_st_drive;
    logic        w_pop;
    logic [7:0]  w_fifo_data;
    logic        w_full;
    logic        w_empty;
    logic        w_drop;
    logic        w_cnt_last;
    logic        w_tx;
    logic [15:0] w_status;
    logic        w_unused;

    // Bus decode. A combined DI+DO cycle still performs the write but the
    // device keeps off the bus to avoid fighting the writer.
    assign w_wr_data   = cpu.DI && (cpu.addr == BASE);
    assign w_st_access = cpu.DO && (cpu.addr == c_STATUS_ADDR);
    assign w_st_drive  = w_st_access && !cpu.DI;
    assign w_unused    = ^bus[15:8];

    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_cnt_last  = (r_cnt == c_CNT_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_wr_data),
        .i_data  (bus[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_status           = '0;
        w_status[ST_BUSY]  = (r_state != S_IDLE);
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_OVF]   = r_ovf;
    end

    assign bus = w_st_drive ? w_status : 16'bz;

    // tx decoded from state so an asynchronous reset forces the line high
    // immediately.
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_shift[0];
            default: w_tx = 1'b1;
        endcase
    end

    assign cpu.tx  = w_tx;
    assign cpu.irq = r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
            r_irq   <= 1'b1;
        end else begin
            r_irq <= (r_state == S_IDLE) && w_empty;

            // A new overflow on the clearing edge takes priority.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_st_access)
                r_ovf <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_fifo_data;
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7)
                            r_state <= S_STOP;
                        else
                            r_bit <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
